alu_seq_multiplier: RTL and testbench
=====================================

Name: alu_seq_multiplier

Overview:
- Iterative unsigned shift-and-add multiplier that sits directly downstream of the n-bit ripple adder datapath.
- Each cycle it consumes one WIDTH-bit sum plus final carry and folds them into a 2*WIDTH product register.
- It gives the ALU a multiply operation with a valid/ready handshake on both sides, so operand sequencing and result capture integrate with the pipelined ALU top.
- The block reuses the existing combinational Full_Adder internally for the accumulate step.

Parameters:
WIDTH  8  operand bit width; legal values 2..32; product width is 2*WIDTH

Ports:
clk        input   1          rising-edge clock, the only clock
rst_n      input   1          synchronous active-low reset, sampled on rising clk
in_valid   input   1          operand pair valid
in_ready   output  1          block can accept operands (high only in IDLE)
in1        input   WIDTH      multiplicand, unsigned
in2        input   WIDTH      multiplier, unsigned
out_valid  output  1          product valid (high only in DONE)
out_ready  input   1          consumer accepts product
out        output  2*WIDTH    product in1*in2, registered
busy       output  1          high in BUSY state

Behaviour:
- Reset: rst_n low at a rising edge forces state=IDLE, out=0, internal acc/count/operands=0.
- Reset values: out_valid=0, busy=0. in_ready is decoded from state, so it is 1 on the first cycle after rst_n returns high.
- State IDLE:
  - in_ready=1, out_valid=0, busy=0.
  - On an edge with in_valid=1, latch mcand=in1, mplier=in2, acc_hi=0, count=0; go to BUSY.
- State BUSY:
  - in_ready=0, busy=1. One iteration per cycle, exactly WIDTH iterations.
  - Each iteration: addend = mplier[0] ? mcand : 0. {c, s} = acc_hi + addend via Full_Adder (WIDTH-bit sum plus final_carry).
  - Then right-shift the (2*WIDTH+1)-bit vector {c, s, mplier} by one: acc_hi <= {c, s[WIDTH-1:1]}, mplier <= {s[0], mplier[WIDTH-1:1]}. count <= count+1.
  - On the edge performing iteration WIDTH-1: out <= final {acc_hi, mplier}; go to DONE.
- Latency: acceptance at edge E0; out_valid is high after edge E_WIDTH, i.e. WIDTH cycles after acceptance. Latency is fixed and data-independent; zero operands get no early exit.
- State DONE:
  - out_valid=1, in_ready=0, busy=0. out is stable while out_valid=1 and out_ready=0 (backpressure holds indefinitely).
  - On an edge with out_ready=1, go to IDLE.
  - No same-cycle accept: the next operand is taken no earlier than the following edge. Maximum throughput is one product per WIDTH+2 cycles.
- out holds the last product after leaving DONE until the next completion or reset. Consumers must qualify out with out_valid.
- Arithmetic: the result is exactly in1*in2 mod 2^(2*WIDTH), which is always exact, so there is no overflow output. The carry from each add is never dropped; it enters the top bit of acc_hi on the shift.
- in1/in2/in_valid changes during BUSY or DONE are ignored. out_ready during IDLE or BUSY is ignored.
- Reset mid-operation in BUSY or DONE abandons the operation. All state returns to reset values on that edge and no out_valid pulse is produced.
- count width is clog2(WIDTH)+1. There is no wrap-around, because the terminal count is WIDTH-1.

Test Plan:
- WIDTH=8, in1=3, in2=5, in_valid 1 cycle, out_ready=1 -> out_valid rises exactly 8 cycles after acceptance edge, out=15, busy high for 8 cycles.
- WIDTH=8, in1=255, in2=255 -> out=65025 (0xFE01); checks carry propagation into acc_hi top bit on every iteration.
- WIDTH=8, in1=0, in2=200 -> out=0 after the full 8-cycle latency; in1=200, in2=1 -> out=200.
- Backpressure: 12*11 with out_ready=0 for 5 cycles after out_valid -> out=132 stable, in_ready=0 throughout; out_ready=1 -> IDLE next edge, in_ready=1.
- Reset mid-op: start 7*9, assert rst_n=0 at the 4th BUSY cycle -> next edge out=0, out_valid=0, busy=0, in_ready=1 after release; then 6*7 -> out=42.
- Back-to-back: stream 10 random pairs with in_valid and out_ready held 1 -> each product matches reference, acceptance edges spaced exactly 10 cycles apart.

Source files
------------

// File: rtl/alu_seq_multiplier.sv
// Iterative unsigned shift-and-add multiplier: one WIDTH-bit accumulate per cycle,
// valid/ready handshake on operand and product sides.
module alu_seq_multiplier #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out,
  output logic               busy
);

  localparam int unsigned CNT_W  = $clog2(WIDTH) + 1;
  localparam int unsigned PROD_W = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0]    mplier_q, mplier_d;
  logic [WIDTH-1:0]    acc_hi_q, acc_hi_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [PROD_W-1:0]   out_q, out_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;

  logic [WIDTH-1:0]    addend;
  logic [WIDTH-1:0]    sum;
  logic [WIDTH:0]      carry;
  logic                final_carry;

  // Accumulate step: ripple chain of full-adder cells, acc_hi + addend
  assign addend   = mplier_q[0] ? mcand_q : '0;
  assign carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]     = acc_hi_q[i] ^ addend[i] ^ carry[i];
    assign carry[i+1] = (acc_hi_q[i] & addend[i]) | (carry[i] & (acc_hi_q[i] ^ addend[i]));
  end

  assign final_carry = carry[WIDTH];

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_hi_d    = acc_hi_q;
    count_d     = count_q;
    out_d       = out_q;
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    busy_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d  = in1;
          mplier_d = in2;
          acc_hi_d = '0;
          count_d  = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        // Shift {carry, sum, mplier} right by one so the carry is never lost
        acc_hi_d = {final_carry, sum[WIDTH-1:1]};
        mplier_d = {sum[0], mplier_q[WIDTH-1:1]};
        count_d  = count_q + CNT_W'(1);
        if (count_q == CNT_W'(WIDTH - 1)) begin
          out_d   = {acc_hi_d, mplier_d};
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d == BUSY);
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_hi_q    <= '0;
      count_q     <= '0;
      out_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_hi_q    <= acc_hi_d;
      count_q     <= count_d;
      out_q       <= out_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out       = out_q;

endmodule

// File: tb/tb_alu_seq_multiplier.sv
// Directed bench for alu_seq_multiplier with a scoreboard of expected products.
module tb_alu_seq_multiplier;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned PW    = 2 * WIDTH;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             out_valid;
  logic             out_ready;
  logic [PW-1:0]    out;
  logic             busy;

  int checks;
  int failures;
  logic [PW-1:0] sb[$];

  alu_seq_multiplier #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PW-1:0] ref_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [PW-1:0] wa;
    logic [PW-1:0] wb;
    wa = PW'(a);
    wb = PW'(b);
    return wa * wb;
  endfunction

  function automatic logic [PW-1:0] sb_pop();
    if (sb.size() == 0) return '1;
    return sb.pop_front();
  endfunction

  // One transaction: accept, measure latency, hold product under backpressure, release
  task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input int bp_cycles);
    int cycles;
    int busy_cycles;
    logic [PW-1:0] exp;
    in1 = a;
    in2 = b;
    in_valid = 1'b1;
    out_ready = 1'b0;
    sb.push_back(ref_mul(a, b));
    step();
    in_valid = 1'b0;
    in1 = WIDTH'($urandom);
    in2 = WIDTH'($urandom);
    chk({tag, "_busy_after_accept"}, 32'(busy), 32'd1);
    chk({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
    cycles = 0;
    busy_cycles = 0;
    while (!out_valid && cycles < 40) begin
      if (busy) busy_cycles++;
      step();
      cycles++;
    end
    chk({tag, "_latency"}, 32'(cycles), 32'(WIDTH));
    chk({tag, "_busy_cycles"}, 32'(busy_cycles), 32'(WIDTH));
    exp = sb_pop();
    chk({tag, "_product"}, 32'(out), 32'(exp));
    for (int i = 0; i < bp_cycles; i++) begin
      step();
      chk({tag, "_bp_out_stable"}, 32'(out), 32'(exp));
      chk({tag, "_bp_out_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_bp_in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_idle_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_idle_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_out_held"}, 32'(out), 32'(exp));
  endtask

  initial begin
    int cyc;
    int got;
    int accepted;
    int last_acc;
    bit acc_now;
    logic [PW-1:0] exp;

    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in1 = '0;
    in2 = '0;

    // Reset state
    step();
    step();
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    step();
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Directed products
    run_op("m3x5", 8'd3, 8'd5, 0);
    run_op("m255x255", 8'd255, 8'd255, 0);
    run_op("m0x200", 8'd0, 8'd200, 0);
    run_op("m200x1", 8'd200, 8'd1, 0);
    run_op("m12x11_bp", 8'd12, 8'd11, 5);

    // Reset in the 4th BUSY cycle abandons the operation
    in1 = 8'd7;
    in2 = 8'd9;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    rst_n = 1'b0;
    step();
    chk("midrst_out", 32'(out), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    step();
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 12; i++) begin
      step();
      chk("midrst_no_valid", 32'(out_valid), 32'd0);
    end
    run_op("m6x7", 8'd6, 8'd7, 0);

    // Back-to-back stream with in_valid and out_ready held high
    in1 = WIDTH'($urandom);
    in2 = WIDTH'($urandom);
    in_valid = 1'b1;
    out_ready = 1'b1;
    cyc = 0;
    got = 0;
    accepted = 0;
    last_acc = -1;
    while (got < 10 && cyc < 400) begin
      acc_now = in_ready && in_valid;
      if (acc_now) begin
        sb.push_back(ref_mul(in1, in2));
        if (last_acc >= 0) chk("b2b_spacing", 32'(cyc - last_acc), 32'(WIDTH + 2));
        last_acc = cyc;
        accepted++;
      end
      if (out_valid) begin
        exp = sb_pop();
        chk("b2b_product", 32'(out), 32'(exp));
        got++;
      end
      step();
      cyc++;
      if (acc_now) begin
        in1 = WIDTH'($urandom);
        in2 = WIDTH'($urandom);
        if (accepted == 10) in_valid = 1'b0;
      end
    end
    chk("b2b_count", 32'(got), 32'd10);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    out_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
